// File: rtl/stall_mem_pkg.sv
// Shared types and constants for the stall_mem_model memory model.
//   state_e   : handshake FSM states (IDLE, WAIT, RESP)
//   LFSR_POLY : Galois feedback taps of the latency LFSR
//   cnt_width : latency down-counter width for a given MIN_LAT / EXTRA_W
package stall_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Wide enough to hold the largest latency MIN_LAT + 2^EXTRA_W - 1.
  function automatic int unsigned cnt_width(input int unsigned min_lat,
                                            input int unsigned extra_w);
    int unsigned w;
    w = $clog2(min_lat + (32'd1 << extra_w));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stall_mem_lfsr.sv
// 32-bit Galois LFSR (right-shifting, taps LFSR_POLY) used to randomise latency.
//   clk, rst    : clock, synchronous active-high reset (loads SEED)
//   lfsr_state  : current register state; advances every non-reset cycle
//   SEED        : reset value; 0 is replaced by 1 so the LFSR never locks up
module stall_mem_lfsr
  import stall_mem_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_000A
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] lfsr_state
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] lfsr_d, lfsr_q;

  // Shift right; fold the polynomial back in when a 1 falls out the bottom.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_POLY;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_state = lfsr_q;

endmodule

// File: rtl/stall_mem_model.sv
// Single-port data-memory model with valid/ready request handshake and
// variable (optionally LFSR-randomised) response latency; one rsp_valid pulse
// per accepted request. Define STALL_MEM_RANDOM_EN to enable random latency;
// otherwise every request takes exactly MIN_LAT cycles.
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake
//   req_wr/req_addr/req_wdata/req_be  : request payload (byte address)
//   rsp_valid/rsp_rdata/rsp_err       : one-cycle response pulse
//   busy                              : request outstanding (pipeline stall)
module stall_mem_model
  import stall_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned MIN_LAT = 1,
  parameter int unsigned EXTRA_W = 2,
  parameter logic [31:0] SEED    = 32'h0000_000A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BOFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = cnt_width(MIN_LAT, EXTRA_W);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'(BYTES);

  logic [EXTRA_W-1:0] extra;

`ifdef STALL_MEM_RANDOM_EN
  logic [31:0] lfsr_state;

  stall_mem_lfsr #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .lfsr_state (lfsr_state)
  );

  assign extra = EXTRA_W'(lfsr_state);
`else
  assign extra = EXTRA_W'(0);
`endif

  // Backing store starts at zero and is deliberately untouched by rst.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               wr_d, wr_q;
  logic               err_d, err_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0]  wdata_d, wdata_q;
  logic [BYTES-1:0]   be_d, be_q;
  logic               req_ready_d, req_ready_q;
  logic               busy_d, busy_q;
  logic               rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_d, rsp_rdata_q;
  logic               rsp_err_d, rsp_err_q;
  logic               mem_we;
  logic [31:0]        lat;

  // Next state, request capture and registered output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    lat         = 32'(MIN_LAT) + 32'(extra);

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          idx_d   = IDX_W'(req_addr >> BOFF_W);
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = ((req_addr & 32'(BYTES - 1)) != 32'd0) ||
                    ({1'b0, req_addr} >= ADDR_LIMIT);
          if (lat == 32'd1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(lat - 32'd2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = wr_q && !err_q;
      end
      default: state_d = IDLE;
    endcase

    // RESP always lasts one cycle, so entering it is the response cycle.
    if (state_d == RESP) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_d;
      rsp_rdata_d = (wr_d || err_d) ? '0 : mem_q[idx_d];
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-masked write commits on the edge that ends RESP; rst drops it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_stall_mem_model.sv
// Directed self-checking bench for stall_mem_model (MIN_LAT=3, DATA_W=32,
// DEPTH=16384). The random-latency scenario runs only when
// STALL_MEM_RANDOM_EN is defined.
module tb_stall_mem_model;

  localparam int unsigned MIN_LAT = 3;
  localparam int unsigned EXTRA_W = 2;
  localparam int          WIN     = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  stall_mem_model #(
    .DATA_W (32),
    .DEPTH  (16384),
    .MIN_LAT(MIN_LAT),
    .EXTRA_W(EXTRA_W),
    .SEED   (32'h0000_000A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic bit lat_ok(input int lat);
`ifdef STALL_MEM_RANDOM_EN
    return (lat >= int'(MIN_LAT)) && (lat <= int'(MIN_LAT) + 3);
`else
    return lat == int'(MIN_LAT);
`endif
  endfunction

  // Issue one request from a negedge with the DUT idle; observe WIN cycles.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat, output int npulse,
                        output logic [31:0] rdata, output logic err,
                        output bit busy_ok);
    req_valid = 1'b1; req_wr = wr; req_addr = addr;
    req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; npulse = 0; rdata = '0; err = 1'b0; busy_ok = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        npulse++;
        if (lat < 0) begin lat = k; rdata = rsp_rdata; err = rsp_err; end
      end
      if (lat < 0 || k == lat) begin
        if (!(busy && !req_ready)) busy_ok = 1'b0;
      end else if (k == lat + 1) begin
        if (!(!busy && req_ready)) busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0)
      $display("FAIL reset_rsp got v=%b e=%b d=%h want zeros", rsp_valid, rsp_err, rsp_rdata);
    else pass_cnt++;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (!(req_ready === 1'b1 && busy === 1'b0 && rsp_valid === 1'b0))
      $display("FAIL reset_no_accept got ready=%b busy=%b want 1 0", req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_fixed_write_read;
    int lat, np; logic [31:0] d; logic e; bit bok;
    do_req(1'b1, 32'h10, 32'h1234_5678, 4'b1111, lat, np, d, e, bok);
    total_cnt++;
    if (!lat_ok(lat) || np != 1) $display("FAIL wr_latency got lat=%0d pulses=%0d want %0d 1", lat, np, MIN_LAT);
    else pass_cnt++;
    total_cnt++;
    if (e !== 1'b0 || d !== 32'h0) $display("FAIL wr_rsp got err=%b data=%h want 0 0", e, d);
    else pass_cnt++;
    total_cnt++;
    if (!bok) $display("FAIL wr_busy got bad busy/ready window want busy through RESP");
    else pass_cnt++;
    do_req(1'b0, 32'h10, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (!lat_ok(lat) || d !== 32'h1234_5678 || e !== 1'b0)
      $display("FAIL rd_data got lat=%0d data=%h err=%b want 0x12345678", lat, d, e);
    else pass_cnt++;
  endtask

  task automatic test_byte_enable;
    int lat, np; logic [31:0] d; logic e; bit bok;
    do_req(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, lat, np, d, e, bok);
    do_req(1'b0, 32'h10, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (d !== 32'h12BB_56DD) $display("FAIL byte_enable got %h want 12bb56dd", d);
    else pass_cnt++;
  endtask

  task automatic test_errors;
    int lat, np; logic [31:0] d; logic e; bit bok;
    do_req(1'b0, 32'h12, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (e !== 1'b1 || d !== 32'h0 || np != 1) $display("FAIL misaligned got err=%b data=%h want 1 0", e, d);
    else pass_cnt++;
    // 0x10000 would alias onto word 0 if the range check were missing.
    do_req(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, lat, np, d, e, bok);
    total_cnt++;
    if (e !== 1'b1 || d !== 32'h0) $display("FAIL out_of_range got err=%b data=%h want 1 0", e, d);
    else pass_cnt++;
    do_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (d !== 32'h0 || e !== 1'b0) $display("FAIL oor_no_write got data=%h err=%b want 0 0", d, e);
    else pass_cnt++;
    do_req(1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 4'b1111, lat, np, d, e, bok);
    do_req(1'b0, 32'h0000_FFFC, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0) $display("FAIL last_word got data=%h err=%b want cafef00d 0", d, e);
    else pass_cnt++;
  endtask

  task automatic test_handshake;
    int accepts = 0, pulses = 0;
    logic [31:0] d = '0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      if (req_valid && req_ready) accepts++;
      @(posedge clk); #1;
      @(negedge clk);
      if (rsp_valid) begin pulses++; d = rsp_rdata; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    total_cnt++;
    if (accepts != 1 || pulses != 1) $display("FAIL held_valid got accepts=%0d pulses=%0d want 1 1", accepts, pulses);
    else pass_cnt++;
    total_cnt++;
    if (d !== 32'h12BB_56DD) $display("FAIL held_valid_data got %h want 12bb56dd", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, np, pulses = 0; logic [31:0] d; logic e; bit bok;
    do_req(1'b1, 32'h20, 32'h1111_1111, 4'b1111, lat, np, d, e, bok);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hDEAD_BEEF; req_be = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_ready got ready=%b busy=%b want 1 0", req_ready, busy);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL rst_mid_rsp got pulses=%0d want 0", pulses);
    else pass_cnt++;
    do_req(1'b0, 32'h20, 32'h0, 4'b0000, lat, np, d, e, bok);
    total_cnt++;
    if (d !== 32'h1111_1111) $display("FAIL rst_mid_mem got %h want 11111111", d);
    else pass_cnt++;
  endtask

`ifdef STALL_MEM_RANDOM_EN
  task automatic run_random(output int lats[$]);
    int lat, np; logic [31:0] d; logic e; bit bok;
    lats = {};
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      do_req(1'b0, 32'(i % 64) << 2, 32'h0, 4'b0000, lat, np, d, e, bok);
      lats.push_back(lat);
    end
  endtask

  task automatic test_random;
    int a[$], b[$];
    int bad = 0, mins = 0, maxs = 0, diff = 0;
    run_random(a);
    run_random(b);
    foreach (a[i]) begin
      if (!lat_ok(a[i])) bad++;
      if (a[i] == int'(MIN_LAT)) mins++;
      if (a[i] == int'(MIN_LAT) + 3) maxs++;
      if (a[i] != b[i]) diff++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL rand_range got %0d out of range want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (mins == 0 || maxs == 0) $display("FAIL rand_extremes got min_hits=%0d max_hits=%0d want both >0", mins, maxs);
    else pass_cnt++;
    total_cnt++;
    if (diff != 0 || a.size() != b.size()) $display("FAIL rand_repeat got %0d differences want 0", diff);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset;
    test_fixed_write_read;
    test_byte_enable;
    test_errors;
    test_handshake;
    test_reset_mid;
`ifdef STALL_MEM_RANDOM_EN
    test_random;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stall_mem_model.md
# stall_mem_model

Parametrised single-port data-memory model with a valid/ready request handshake and variable response latency. Latency is driven by a seeded LFSR, which exercises pipeline stall logic reproducibly. Each request returns exactly one response pulse, with optional byte-enable writes and an alignment/range error flag. It sits behind the pipeline's memory stage, or the fetch stage, as the simulation stand-in for backing memory.

## Interface
- DATA_W, 32: data width in bits; power of 2, ≥ 8
- DEPTH, 16384: number of DATA_W words
- MIN_LAT, 1: minimum response latency in cycles; ≥ 1
- EXTRA_W, 2: width of the random extra-latency field; extra latency ranges 0..2^EXTRA_W−1
- SEED, 32'h0000_000A: LFSR seed; a value of 0 is replaced by 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; used for writes only
- rsp_valid  out  1  single-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  error flag; valid while rsp_valid is high
- busy  out  1  request outstanding (the pipeline's stall indication)

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1, busy=0.
  - WAIT and RESP: req_ready=0, busy=1.
- Accept: req_valid & req_ready on a clock edge. At that edge the block captures wr, addr, wdata and be, and computes latency L = MIN_LAT + extra.
- Transitions out of accept: L=1 goes to RESP. L>1 goes to WAIT with the down-counter set to L−2.
- WAIT: the counter decrements each cycle. When it reaches 0, the next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Word index = req_addr[log2(DATA_W/8) +: log2(DEPTH)].
- Error when either:
  - req_addr[log2(DATA_W/8)−1:0] ≠ 0, or
  - req_addr ≥ DEPTH·DATA_W/8.
- On error: rsp_err=1, rsp_rdata=0, no memory write.
- Read: rsp_rdata = mem[index], sampled in the RESP cycle.
- Write: commits on the clock edge ending RESP. Only bytes with req_be[i]=1 are written. rsp_rdata=0.
- Read-after-write to the same address returns the new data, because requests are serialised.
- LFSR:
  - 32-bit Galois, polynomial 0x80200003.
  - Advances every non-reset cycle, regardless of state.
  - extra = lfsr[EXTRA_W−1:0], sampled at accept.
- Memory array is zero-initialised at time 0.

## Timing
- Request accepted at edge E0: rsp_valid is high in the cycle after edge E(L−1), i.e. L cycles after acceptance.
- req_ready returns to 1 in the cycle after RESP. Maximum throughput is one request per L+1 cycles.
- While req_ready=0, a held req_valid is ignored. The request is accepted once, when IDLE is re-entered.
- Counter width is clog2(MIN_LAT + 2^EXTRA_W) bits. The counter never wraps, because it only decrements from ≤ L−2.
- Reset values: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, lfsr=SEED.
- Reset in WAIT or RESP:
  - The outstanding request is dropped and no response is issued.
  - A pending write is not committed.
  - Memory contents are not altered by rst.
- req_valid asserted during rst is not accepted.

## Configuration
- STALL_MEM_RANDOM_EN defined: the LFSR is instantiated and extra latency is random as above.
- STALL_MEM_RANDOM_EN undefined: no LFSR, extra=0, and latency is fixed at MIN_LAT for every request.

## Structure
- Package stall_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - LFSR_POLY = 32'h80200003;
  - the function computing counter width from MIN_LAT and EXTRA_W.
- Sub-module stall_mem_lfsr: 32-bit Galois LFSR with clk, rst, SEED parameter and 32-bit state output. It is instantiated only under STALL_MEM_RANDOM_EN.

## Test plan
- Fixed latency, macro off, MIN_LAT=3:
  - Write 0x12345678 to 0x10 with be=4'b1111, accepted at cycle 0 → rsp_valid only in cycle 3, rsp_err=0.
  - Read 0x10 → rsp_rdata=0x12345678.
- Byte enables: write 0xAABBCCDD to 0x10 with be=4'b0101 over 0x12345678 → read 0x10 returns 0x12BB56DD.
- Errors:
  - Read 0x12 → rsp_err=1, rsp_rdata=0.
  - Write 0x10000 (DEPTH=16384) → rsp_err=1, memory unchanged.
- Handshake: hold req_valid=1 with a single request for 10 cycles → exactly one accept and one rsp_valid. busy=1 from the accept edge through RESP.
- Reset mid-operation: assert rst for 1 cycle during WAIT of a write of 0xDEADBEEF to 0x20 → no rsp_valid. req_ready=1 after rst deasserts. Read 0x20 returns the old value.
- Random latency, macro on, EXTRA_W=2, 1000 requests:
  - Every latency lies in [MIN_LAT, MIN_LAT+3], and both MIN_LAT and MIN_LAT+3 are observed.
  - Rerunning with the same SEED reproduces an identical latency sequence.
